// File: rtl/morse_ascii_decoder.sv
// ============================================================================
// morse_ascii_decoder : tick-sampled Morse keyed line to ASCII (A-Z, 0-9, space)
// Revision: 1.0
// ============================================================================
`default_nettype none

module morse_ascii_decoder #(
  parameter int CNT_W    = 4,
  parameter int DOT_MAX  = 2,
  parameter int DASH_MIN = 3,
  parameter int DASH_MAX = 5,
  parameter int CHAR_GAP = 3,
  parameter int WORD_GAP = 7,
  parameter int MAX_SYM  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mors,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       err,
  output logic       busy
);

  localparam int SC_W  = $clog2(MAX_SYM + 1);
  localparam int EXT_W = (MAX_SYM > 5) ? MAX_SYM : 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MARK = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_MAX_C  = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] DASH_MAX_C = CNT_W'(DASH_MAX);
  localparam logic [CNT_W-1:0] CHAR_GAP_C = CNT_W'(CHAR_GAP);
  localparam logic [CNT_W-1:0] WORD_GAP_C = CNT_W'(WORD_GAP);
  localparam logic [SC_W-1:0]  MAX_SYM_C  = SC_W'(MAX_SYM);

  logic [1:0]         state;
  logic [CNT_W-1:0]   mark_cnt;
  logic [CNT_W-1:0]   gap_cnt;
  logic [MAX_SYM-1:0] sym_buf;
  logic [SC_W-1:0]    sym_cnt;
  logic               bad;
  logic               space_armed;

  logic               is_dot;
  logic               is_dash;
  logic [MAX_SYM-1:0] app_buf;
  logic [SC_W-1:0]    app_cnt;
  logic               app_bad;
  logic [CNT_W-1:0]   gap_next;
  logic [EXT_W-1:0]   buf_ext;
  logic [7:0]         len_ext;
  logic [8:0]         dec;

  // Returns {match, ascii}; code holds the symbols with the oldest in the MSB.
  function automatic logic [8:0] decode(input logic [7:0] len, input logic [4:0] code);
    logic [8:0] r;
    r = 9'h000;
    case (len)
      8'd1: r = code[0] ? 9'h154 : 9'h145;
      8'd2:
        case (code[1:0])
          2'b00:   r = 9'h149;
          2'b01:   r = 9'h141;
          2'b10:   r = 9'h14E;
          default: r = 9'h14D;
        endcase
      8'd3:
        case (code[2:0])
          3'b000:  r = 9'h153;
          3'b001:  r = 9'h155;
          3'b010:  r = 9'h152;
          3'b011:  r = 9'h157;
          3'b100:  r = 9'h144;
          3'b101:  r = 9'h14B;
          3'b110:  r = 9'h147;
          default: r = 9'h14F;
        endcase
      8'd4:
        case (code[3:0])
          4'b0000: r = 9'h148;
          4'b0001: r = 9'h156;
          4'b0010: r = 9'h146;
          4'b0100: r = 9'h14C;
          4'b0110: r = 9'h150;
          4'b0111: r = 9'h14A;
          4'b1000: r = 9'h142;
          4'b1001: r = 9'h158;
          4'b1010: r = 9'h143;
          4'b1011: r = 9'h159;
          4'b1100: r = 9'h15A;
          4'b1101: r = 9'h151;
          default: r = 9'h000;
        endcase
      8'd5:
        case (code)
          5'b11111: r = 9'h130;
          5'b01111: r = 9'h131;
          5'b00111: r = 9'h132;
          5'b00011: r = 9'h133;
          5'b00001: r = 9'h134;
          5'b00000: r = 9'h135;
          5'b10000: r = 9'h136;
          5'b11000: r = 9'h137;
          5'b11100: r = 9'h138;
          5'b11110: r = 9'h139;
          default:  r = 9'h000;
        endcase
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  // Buffer contents as they stand after the current low sample, so that a
  // mark ending and a character ending on one edge are handled together.
  always_comb begin
    is_dot  = (mark_cnt >= CNT_ONE) && (mark_cnt <= DOT_MAX_C);
    is_dash = (mark_cnt >= DASH_MIN_C) && (mark_cnt <= DASH_MAX_C);
    app_buf = sym_buf;
    app_cnt = sym_cnt;
    app_bad = bad;
    if (state == MARK) begin
      if (sym_cnt == MAX_SYM_C) begin
        app_bad = 1'b1;
      end else begin
        app_buf = (sym_buf << 1) | MAX_SYM'(is_dash);
        app_cnt = sym_cnt + SC_W'(1);
        if (!is_dot && !is_dash) app_bad = 1'b1;
      end
    end
    if (state == MARK)
      gap_next = CNT_ONE;
    else if (gap_cnt == CNT_SAT)
      gap_next = gap_cnt;
    else
      gap_next = gap_cnt + CNT_ONE;
    buf_ext = EXT_W'(app_buf);
    len_ext = 8'(app_cnt);
    dec     = decode(len_ext, buf_ext[4:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mark_cnt    <= '0;
      gap_cnt     <= '0;
      sym_buf     <= '0;
      sym_cnt     <= '0;
      bad         <= 1'b0;
      space_armed <= 1'b0;
      char_out    <= 8'h00;
      char_valid  <= 1'b0;
      err         <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      err        <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (mors) begin
              state    <= MARK;
              mark_cnt <= CNT_ONE;
            end
          end
          MARK, GAP: begin
            if (mors) begin
              if (state == MARK) begin
                if (mark_cnt != CNT_SAT) mark_cnt <= mark_cnt + CNT_ONE;
              end else begin
                state    <= MARK;
                mark_cnt <= CNT_ONE;
              end
            end else begin
              state   <= GAP;
              gap_cnt <= gap_next;
              sym_buf <= app_buf;
              sym_cnt <= app_cnt;
              bad     <= app_bad;
              if (gap_next == CHAR_GAP_C) begin
                if (!app_bad && dec[8]) begin
                  char_out   <= dec[7:0];
                  char_valid <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
                sym_buf     <= '0;
                sym_cnt     <= '0;
                bad         <= 1'b0;
                space_armed <= 1'b1;
              end else if (gap_next == WORD_GAP_C) begin
                if (space_armed) begin
                  char_out   <= 8'h20;
                  char_valid <= 1'b1;
                end
                space_armed <= 1'b0;
                state       <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state == MARK) || (sym_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_morse_ascii_decoder.sv
// ============================================================================
// tb_morse_ascii_decoder : directed self-checking bench for morse_ascii_decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_morse_ascii_decoder;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       tick = 1'b0;
  logic       mors = 1'b0;
  logic [7:0] char_out;
  logic       char_valid;
  logic       err;
  logic       busy;

  int tests      = 0;
  int fails      = 0;
  int div        = 1;
  int both_hi    = 0;
  int ticks_seen = 0;
  int base       = 0;

  logic [8:0] ev_q[$];
  int         ev_t[$];

  morse_ascii_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .mors       (mors),
    .char_out   (char_out),
    .char_valid (char_valid),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tick) ticks_seen++;

  // Every strobe cycle is logged as {err, char_out} with its tick number.
  always @(negedge clk) begin
    if (char_valid || err) begin
      ev_q.push_back({err, char_out});
      ev_t.push_back(ticks_seen);
      if (char_valid && err) both_hi++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ev(input int i);
    return (i < ev_q.size()) ? ev_q[i] : 9'h1FF;
  endfunction

  function automatic int evt(input int i);
    return (i < ev_t.size()) ? ev_t[i] - base : -1;
  endfunction

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mors = v;
      tick = 1'b1;
      for (int k = 1; k < div; k++) begin
        @(negedge clk);
        tick = 1'b0;
        mors = ~mors;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    tick = 1'b0;
    mors = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 1'b0;
    mors = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    ev_q.delete();
    ev_t.delete();
    base = ticks_seen;
  endtask

  task automatic send_a();
    drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 3); drive(1'b0, 3);
  endtask

  initial begin
    do_reset();
    check("rst_char_out", 32'(char_out), 32'h00);
    check("rst_valid", 32'(char_valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // 'A' at one tick per clock
    send_a();
    settle();
    check("a_count", ev_q.size(), 1);
    check("a_value", 32'(ev(0)), 32'h041);
    check("a_tick", evt(0), 8);

    // '5' then '0'
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1); drive(1'b0, 1); end
    drive(1'b1, 1); drive(1'b0, 3);
    for (int i = 0; i < 4; i++) begin drive(1'b1, 3); drive(1'b0, 1); end
    drive(1'b1, 3); drive(1'b0, 3);
    settle();
    check("digit_count", ev_q.size(), 2);
    check("digit_5", 32'(ev(0)), 32'h035);
    check("digit_0", 32'(ev(1)), 32'h030);

    // 'E' then word gap, then long silence
    do_reset();
    drive(1'b1, 1); drive(1'b0, 10);
    drive(1'b0, 20);
    settle();
    check("word_count", ev_q.size(), 2);
    check("word_e", 32'(ev(0)), 32'h045);
    check("word_e_tick", evt(0), 4);
    check("word_space", 32'(ev(1)), 32'h020);
    check("word_space_tick", evt(1), 8);
    check("word_busy", 32'(busy), 32'h0);

    // bad mark length and symbol overflow keep char_out from 'T'
    do_reset();
    drive(1'b1, 3); drive(1'b0, 3);
    drive(1'b1, 6); drive(1'b0, 3);
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1); drive(1'b0, 1); end
    drive(1'b1, 1); drive(1'b0, 3);
    settle();
    check("err_count", ev_q.size(), 3);
    check("err_t", 32'(ev(0)), 32'h054);
    check("err_long", 32'(ev(1)), 32'h154);
    check("err_overflow", 32'(ev(2)), 32'h154);
    check("err_char_out", 32'(char_out), 32'h54);

    // 'A' with tick every 4th clock and mors toggling between ticks
    do_reset();
    div = 4;
    send_a();
    settle();
    div = 1;
    check("slow_count", ev_q.size(), 1);
    check("slow_value", 32'(ev(0)), 32'h041);
    check("slow_tick", evt(0), 8);

    // async reset partway through 'D', then 'T'
    do_reset();
    drive(1'b1, 3); drive(1'b0, 1); drive(1'b1, 1); drive(1'b0, 1);
    @(negedge clk);
    tick = 1'b0;
    mors = 1'b0;
    check("d_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 3); drive(1'b0, 3);
    settle();
    check("rst_t_count", ev_q.size(), 1);
    check("rst_t_value", 32'(ev(0)), 32'h054);

    check("valid_err_overlap", both_hi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
